// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the two-master bus arbiter.
// State encoding and default data width.
package bus_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_mux.sv
// Two-input multiplexer feeding the shared bus.
// Purely combinational: out = select ? in1 : in0.
module Multiplexer #(
  parameter int inputWidth = 8
) (
  input  logic [inputWidth-1:0] in0,
  input  logic [inputWidth-1:0] in1,
  input  logic                  select,
  output logic [inputWidth-1:0] out
);

  assign out = select ? in1 : in0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for two bus masters sharing a 2:1 mux.
// Optional hold timeout compiled in with ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int dataWidth = DEFAULT_WIDTH,
  parameter int maxHold   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 done0,
  input  logic                 done1,
  input  logic [dataWidth-1:0] data0,
  input  logic [dataWidth-1:0] data1,
  output logic                 grant0,
  output logic                 grant1,
  output logic                 select,
  output logic [dataWidth-1:0] busOut,
  output logic                 busValid,
  output logic                 timeout
);

  if (maxHold < 2 || maxHold > 255) begin : g_bad_hold
    $error("bus_arbiter: maxHold out of range 2..255");
  end

  state_e r_state;
  state_e w_next;
  logic   r_last;
  logic   r_sel;
  logic   r_grant0;
  logic   r_grant1;
  logic   r_valid;
  logic   r_timeout;
  logic   w_done;
  logic   w_forced;
  logic   w_release;
  logic   w_enter;

  always_comb begin
    w_next    = r_state;
    w_done    = ((r_state == ST_OWN0) && done0)
             || ((r_state == ST_OWN1) && done1);
    w_release = w_done || w_forced;
    unique case (r_state)
      ST_IDLE: begin
        if (req0 && req1)
          w_next = r_last ? ST_OWN0 : ST_OWN1;
        else if (req0)
          w_next = ST_OWN0;
        else if (req1)
          w_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (w_release)
          w_next = req1 ? ST_OWN1 : ST_IDLE;
      end
      ST_OWN1: begin
        if (w_release)
          w_next = req0 ? ST_OWN0 : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    w_enter = (w_next != ST_IDLE) && (w_next != r_state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_grant0  <= (w_next == ST_OWN0);
      r_grant1  <= (w_next == ST_OWN1);
      r_valid   <= (w_next != ST_IDLE);
      r_timeout <= w_forced && !w_done;
      // select and lastOwner only move on grant entry
      if (w_enter) begin
        r_last <= (w_next == ST_OWN1);
        r_sel  <= (w_next == ST_OWN1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(maxHold - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= 8'd0;
    else if (w_enter || (r_state == ST_IDLE))
      r_cnt <= 8'd0;
    else
      r_cnt <= r_cnt + 8'd1;
  end

  assign w_forced = (r_state != ST_IDLE) && (r_cnt == HOLD_LAST);
`else
  assign w_forced = 1'b0;
`endif

  Multiplexer #(
    .inputWidth(dataWidth)
  ) u_mux (
    .in0   (data0),
    .in1   (data1),
    .select(r_sel),
    .out   (busOut)
  );

  assign grant0   = r_grant0;
  assign grant1   = r_grant1;
  assign select   = r_sel;
  assign busValid = r_valid;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed literal checks plus random traffic
// compared every cycle against a behavioural owner/hold model.
module tb_bus_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, done0, done1;
  logic [W-1:0] data0, data1, busOut;
  logic         grant0, grant1, select, busValid, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  bus_arbiter #(
    .dataWidth(W),
    .maxHold  (MH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .done0   (done0),
    .done1   (done1),
    .data0   (data0),
    .data1   (data1),
    .grant0  (grant0),
    .grant1  (grant1),
    .select  (select),
    .busOut  (busOut),
    .busValid(busValid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: owner -1 = nobody, held = cycles the current grant has lasted
  int m_own  = -1;
  int m_last = 1;
  int m_sel  = 0;
  int m_held = 0;
  bit m_to   = 1'b0;

  always @(posedge clk) begin
    int nxt;
    bit dn, forced, oreq;
    if (reset) begin
      m_own = -1; m_last = 1; m_sel = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      nxt  = m_own;
      if (m_own < 0) begin
        if (req0 && req1) nxt = 1 - m_last;
        else if (req0)    nxt = 0;
        else if (req1)    nxt = 1;
      end else begin
        dn     = (m_own == 0) ? done0 : done1;
        forced = TO_EN && (m_held >= MH) && !dn;
        if (dn || forced) begin
          oreq = (m_own == 0) ? req1 : req0;
          nxt  = oreq ? 1 - m_own : -1;
          m_to = forced;
        end
      end
      if (nxt >= 0 && nxt != m_own) begin
        m_last = nxt; m_sel = nxt; m_held = 1;
      end else if (nxt >= 0) begin
        m_held++;
      end
      m_own = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_grant0", 32'(grant0), 32'(m_own == 0));
      chk("m_grant1", 32'(grant1), 32'(m_own == 1));
      chk("m_valid", 32'(busValid), 32'(m_own >= 0));
      chk("m_select", 32'(select), 32'(m_sel));
      chk("m_busOut", 32'(busOut), 32'((m_sel != 0) ? data1 : data0));
      chk("m_timeout", 32'(timeout), 32'(m_to));
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
    data0 = 8'hA5; data1 = 8'h3C;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_grant0", 32'(grant0), 32'd0);
    chk("rst_grant1", 32'(grant1), 32'd0);
    chk("rst_valid", 32'(busValid), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_busOut", 32'(busOut), 32'hA5);
    reset = 1'b0;

    req0 = 1'b1;
    tick();
    chk("req0_grant0", 32'(grant0), 32'd1);
    chk("req0_select", 32'(select), 32'd0);
    chk("req0_valid", 32'(busValid), 32'd1);
    req0 = 1'b0; done0 = 1'b1;
    tick();
    done0 = 1'b0;
    chk("done0_grant0", 32'(grant0), 32'd0);
    chk("done0_valid", 32'(busValid), 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("tie_grant0", 32'(grant0), 32'd1);
    chk("tie_grant1", 32'(grant1), 32'd0);
    req0 = 1'b0; done0 = 1'b1;
    tick();
    done0 = 1'b0;
    chk("ho_grant0", 32'(grant0), 32'd0);
    chk("ho_grant1", 32'(grant1), 32'd1);
    chk("ho_valid", 32'(busValid), 32'd1);
    chk("ho_select", 32'(select), 32'd1);
    chk("ho_busOut", 32'(busOut), 32'h3C);

    req1 = 1'b0; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    req0 = 1'b1;
    tick();
    chk("ign_pre", 32'(grant0), 32'd1);
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    chk("ign_done1", 32'(grant0), 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst_grant0", 32'(grant0), 32'd0);
    chk("midrst_valid", 32'(busValid), 32'd0);
    chk("midrst_select", 32'(select), 32'd0);
    chk("midrst_tmo", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();
    chk("rearb_grant0", 32'(grant0), 32'd1);
    req0 = 1'b0; done0 = 1'b1;
    tick();
    done0 = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt%0d_g0", i), 32'(grant0), 32'(i % 2 == 0));
      chk($sformatf("alt%0d_g1", i), 32'(grant1), 32'(i % 2 == 1));
      tick();
      done0 = 1'b1; done1 = 1'b1;
      tick();
      done0 = 1'b0; done1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0; done0 = 1'b1; done1 = 1'b1;
    tick();
    done0 = 1'b0; done1 = 1'b0;
    tick();

    req0 = 1'b1;
    tick();
    n = 0;
    while (grant0 && n < 100) begin
      n++;
      tick();
    end
    if (TO_EN) begin
      chk("hold_cycles", 32'(n), 32'(MH));
      chk("hold_tmo", 32'(timeout), 32'd1);
    end else begin
      chk("hold_cycles", 32'(n), 32'd100);
      chk("hold_tmo", 32'(timeout), 32'd0);
    end
    req0 = 1'b0; done0 = 1'b1;
    tick();
    done0 = 1'b0;
    tick();

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      done0 = ($urandom_range(0, 3) == 0);
      done1 = ($urandom_range(0, 3) == 0);
      data0 = W'($urandom);
      data1 = W'($urandom);
      tick();
    end

    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
